// File: rtl/spike_mac_sched_pkg.sv
// Shared widths and FSM encoding for the spike MAC sequencer.
package spike_mac_sched_pkg;
  localparam int N_ROWS    = 8;
  localparam int N_COLS    = 8;
  localparam int W_WIDTH   = 8;
  // Eight 8-bit weights summed: 8*255 = 2040 fits in 11 bits.
  localparam int OUT_WIDTH = W_WIDTH + $clog2(N_ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } sched_state_t;
endpackage

// File: rtl/spike_mac_sched_mac.sv
// Combinational spike MAC: per column, sums the weights of every row whose spike bit is set.
module spike_mac_sched_mac
  import spike_mac_sched_pkg::*;
(
  input  logic [N_ROWS-1:0]                            spk,
  input  logic [N_ROWS-1:0][N_COLS-1:0][W_WIDTH-1:0]   w,
  output logic [N_COLS-1:0][OUT_WIDTH-1:0]             mac
);
  always_comb begin
    mac = '0;
    for (int c = 0; c < N_COLS; c++) begin
      for (int i = 0; i < N_ROWS; i++) begin
        if (spk[i]) mac[c] = mac[c] + OUT_WIDTH'(w[i][c]);
      end
    end
  end
endmodule

// File: rtl/spike_mac_sched.sv
// Spike MAC sequencer: holds the weight matrix, streams spike vectors through one pipe
// stage into per-column accumulators and returns one result frame per start.
module spike_mac_sched
  import spike_mac_sched_pkg::*;
#(
  parameter int STEP_W = 4,
  parameter int ACC_W  = OUT_WIDTH + STEP_W
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_we,
  input  logic [$clog2(N_ROWS)-1:0]            cfg_row,
  input  logic [N_COLS-1:0][W_WIDTH-1:0]       cfg_data,
  output logic                                 cfg_ready,
  input  logic                                 start,
  input  logic [STEP_W-1:0]                    num_steps,
  input  logic                                 spk_valid,
  input  logic [N_ROWS-1:0]                    spk_data,
  output logic                                 spk_ready,
  output logic                                 out_valid,
  output logic [N_COLS-1:0][ACC_W-1:0]         out_sum,
  input  logic                                 out_ready,
  output logic                                 busy,
  output sched_state_t                         dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // a producer holds valid and its data stable until that edge, and ready never waits on valid.

  sched_state_t                               state;
  logic [N_ROWS-1:0][N_COLS-1:0][W_WIDTH-1:0] w_q;
  logic [N_COLS-1:0][OUT_WIDTH-1:0]           mac;
  logic [N_COLS-1:0][OUT_WIDTH-1:0]           pipe_q;
  logic                                       pipe_v;
  logic [N_COLS-1:0][ACC_W-1:0]               acc_q;
  logic [N_COLS-1:0][ACC_W-1:0]               acc_next;
  logic [STEP_W-1:0]                          steps_q;
  logic [STEP_W-1:0]                          cnt_q;
  logic                                       spk_fire;

  spike_mac_sched_mac u_mac (
    .spk (spk_data),
    .w   (w_q),
    .mac (mac)
  );

  assign cfg_ready = (state == IDLE);
  assign spk_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign spk_fire  = spk_valid & spk_ready;

  always_comb begin
    for (int c = 0; c < N_COLS; c++) begin
      acc_next[c] = acc_q[c] + (pipe_v ? ACC_W'(pipe_q[c]) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      w_q       <= '0;
      pipe_q    <= '0;
      pipe_v    <= 1'b0;
      acc_q     <= '0;
      steps_q   <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      acc_q  <= acc_next;
      pipe_v <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_we) w_q[cfg_row] <= cfg_data;
          if (start && num_steps != '0) begin
            steps_q <= num_steps;
            cnt_q   <= '0;
            acc_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (spk_fire) begin
            pipe_q <= mac;
            pipe_v <= 1'b1;
            cnt_q  <= cnt_q + STEP_W'(1);
            if (cnt_q + STEP_W'(1) == steps_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last pipe entry is folded in here so out_sum sees the complete frame.
          out_sum   <= acc_next;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spike_mac_sched.sv
// Directed bench for spike_mac_sched: drivers push expected frames, a monitor pops on out_valid&out_ready.
module tb_spike_mac_sched;
  import spike_mac_sched_pkg::*;

  localparam int STEP_W = 4;
  localparam int ACC_W  = OUT_WIDTH + STEP_W;
  localparam int SUM_W  = N_COLS * ACC_W;

  logic                         clk;
  logic                         rst_n;
  logic                         cfg_we;
  logic [2:0]                   cfg_row;
  logic [7:0][7:0]              cfg_data;
  logic                         cfg_ready;
  logic                         start;
  logic [STEP_W-1:0]            num_steps;
  logic                         spk_valid;
  logic [7:0]                   spk_data;
  logic                         spk_ready;
  logic                         out_valid;
  logic [7:0][ACC_W-1:0]        out_sum;
  logic                         out_ready;
  logic                         busy;
  sched_state_t                 dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SUM_W-1:0] exp_q[$];
  int w_model[8][8];
  int acc_model[8];

  spike_mac_sched #(.STEP_W(STEP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_row   (cfg_row),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .start     (start),
    .num_steps (num_steps),
    .spk_valid (spk_valid),
    .spk_data  (spk_data),
    .spk_ready (spk_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_sum(input string name, input logic [SUM_W-1:0] act, input logic [SUM_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  function automatic logic [SUM_W-1:0] pack_model();
    logic [SUM_W-1:0] r;
    r = '0;
    for (int c = 0; c < 8; c++) r[c*ACC_W +: ACC_W] = ACC_W'(acc_model[c]);
    return r;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=%h expected=none", out_sum);
      end else begin
        check_sum("frame_sum", out_sum, exp_q.pop_front());
      end
    end
  end

  // drivers: each task starts and ends 1 time unit after a rising edge
  task automatic load_row(input int r, input logic [7:0][7:0] d, input bit track);
    cfg_we   = 1'b1;
    cfg_row  = 3'(r);
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (track) for (int c = 0; c < 8; c++) w_model[r][c] = int'(d[c]);
  endtask

  task automatic start_frame(input int n);
    start     = 1'b1;
    num_steps = STEP_W'(n);
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 8; c++) acc_model[c] = 0;
  endtask

  task automatic send_spk(input logic [7:0] d);
    int t;
    t = 0;
    spk_valid = 1'b1;
    spk_data  = d;
    @(negedge clk);
    while (!spk_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL spk_timeout actual=not_ready expected=ready");
    end
    @(posedge clk);
    #1 spk_valid = 1'b0;
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < 8; i++)
        if (d[i]) acc_model[c] += w_model[i][c];
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_bit("idle_reached", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0][7:0]  d;
    logic [SUM_W-1:0] e;
    int               t;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_row = '0; cfg_data = '0; start = 1'b0;
    num_steps = '0; spk_valid = 1'b0; spk_data = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) for (int c = 0; c < 8; c++) w_model[i][c] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("rst_cfg_ready", cfg_ready, 1'b1);
    check_bit("rst_spk_ready", spk_ready, 1'b0);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_sum("rst_out_sum", out_sum, '0);
    rst_n = 1'b1;
    gap(1);

    // 1: W[i][c]=i*8+c, one all-ones vector -> 224+8c, out_valid two edges after accept
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) d[c] = 8'(r * 8 + c);
      load_row(r, d, 1'b1);
    end
    e = '0;
    for (int c = 0; c < 8; c++) e[c*ACC_W +: ACC_W] = ACC_W'(224 + 8 * c);
    exp_q.push_back(e);
    start_frame(1);
    send_spk(8'hFF);
    @(negedge clk);
    check_bit("lat_edge_n1", out_valid, 1'b0);
    check_bit("drain_busy", busy, 1'b1);
    @(negedge clk);
    check_bit("lat_edge_n2", out_valid, 1'b1);
    wait_idle();

    // 2: all weights 255, 15 back-to-back vectors -> 30600 per column
    for (int c = 0; c < 8; c++) d[c] = 8'hFF;
    for (int r = 0; r < 8; r++) load_row(r, d, 1'b1);
    e = '0;
    for (int c = 0; c < 8; c++) e[c*ACC_W +: ACC_W] = ACC_W'(30600);
    exp_q.push_back(e);
    start_frame(15);
    repeat (15) send_spk(8'hFF);
    @(negedge clk);
    check_bit("ready_drop", spk_ready, 1'b0);
    check_bit("state_drain", dbg_state == DRAIN, 1'b1);
    wait_idle();

    // 3: identity*10 weights, gapped vectors 01,00,80 -> col0=10, col7=10
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) d[c] = (c == r) ? 8'd10 : 8'd0;
      load_row(r, d, 1'b1);
    end
    e = '0;
    e[0*ACC_W +: ACC_W] = ACC_W'(10);
    e[7*ACC_W +: ACC_W] = ACC_W'(10);
    exp_q.push_back(e);
    start_frame(3);
    send_spk(8'h01);
    gap(2);
    send_spk(8'h00);
    gap(3);
    send_spk(8'h80);
    wait_idle();

    // 4: consumer stalls 5 cycles; output held, cfg_we/start ignored
    out_ready = 1'b0;
    start_frame(2);
    send_spk(8'h02);
    send_spk(8'h03);
    e = pack_model();
    exp_q.push_back(e);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_bit("stall_valid_seen", out_valid, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
      cfg_we = 1'b1; cfg_row = 3'd0; cfg_data = {8{8'hFF}};
      start = 1'b1; num_steps = 4'd5;
      @(negedge clk);
      check_bit("stall_valid", out_valid, 1'b1);
      check_sum("stall_sum", out_sum, e);
    end
    @(posedge clk);
    #1;
    cfg_we = 1'b0; start = 1'b0; out_ready = 1'b1;
    wait_idle();
    start_frame(1);
    send_spk(8'h01);
    exp_q.push_back(pack_model());
    wait_idle();

    // 5: weight write during RUN ignored; zero-step start ignored
    start_frame(1);
    load_row(2, {8{8'hFF}}, 1'b0);
    send_spk(8'h04);
    exp_q.push_back(pack_model());
    wait_idle();
    start_frame(0);
    @(negedge clk);
    check_bit("zero_steps_busy", busy, 1'b0);
    check_bit("zero_steps_cfg_ready", cfg_ready, 1'b1);
    gap(1);

    // 6: reset after 2 of 4 accepts aborts the frame and clears weights
    start_frame(4);
    send_spk(8'h01);
    send_spk(8'h02);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_bit("abort_busy", busy, 1'b0);
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_bit("abort_spk_ready", spk_ready, 1'b0);
    check_bit("abort_cfg_ready", cfg_ready, 1'b1);
    check_sum("abort_out_sum", out_sum, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) for (int c = 0; c < 8; c++) w_model[i][c] = 0;
    gap(1);
    start_frame(1);
    send_spk(8'hFF);
    exp_q.push_back(pack_model());
    wait_idle();
    for (int c = 0; c < 8; c++) d[c] = 8'(c + 1);
    load_row(3, d, 1'b1);
    for (int c = 0; c < 8; c++) d[c] = 8'd100;
    load_row(5, d, 1'b1);
    start_frame(2);
    send_spk(8'h28);
    send_spk(8'h08);
    exp_q.push_back(pack_model());
    wait_idle();

    gap(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_outstanding actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
